// File: rtl/char_uart_tx_pkg.sv
// Shared types and constants for the character UART transmitter and its input FIFO.
package char_uart_tx_pkg;

    localparam int   CHAR_W  = 7;
    localparam logic TX_IDLE = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/char_fifo.sv
// Small synchronous character FIFO; dout shows the head entry, so a new entry is
// only visible once its push edge has updated the count.
module char_fifo
    import char_uart_tx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [CHAR_W-1:0]        din,
    output logic [CHAR_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [CHAR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/char_uart_tx.sv
// Buffers 7-bit characters and serializes them as start, LSB-first data,
// optional even parity and stop bits, flagging characters dropped on a full FIFO.
module char_uart_tx
    import char_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter bit PARITY_EN    = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CHAR_W-1:0]             in_char,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(CHAR_W - 1);

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [CHAR_W-1:0]  shift_q, shift_d;
    logic               parity_q, parity_d;
    logic               tx_q, tx_d;
    logic               overflow_q;
    logic               pop;
    logic               bit_end;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CHAR_W-1:0]  fifo_dout;

    char_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid && in_ready),
        .pop   (pop),
        .din   (in_char),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign in_ready = !fifo_full;
    assign busy     = (state_q != IDLE);
    assign overflow = overflow_q;
    assign tx       = tx_q;
    assign bit_end  = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        pop      = 1'b0;
        if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
        end
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    shift_d  = fifo_dout;
                    parity_d = ^fifo_dout;
                    bit_d    = '0;
                    baud_d   = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = PARITY_EN ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                // Chain straight into the next frame so queued characters leave no idle gap.
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        shift_d  = fifo_dout;
                        parity_d = ^fifo_dout;
                        bit_d    = '0;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        tx_d = TX_IDLE;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= TX_IDLE;
            overflow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            if (in_valid && fifo_full) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_char_uart_tx.sv
// Directed bench for char_uart_tx: two instances cover the 4-clock parity build
// and the 1-clock no-parity build; serial output is logged and compared to a frame model.
module tb_char_uart_tx;

    logic       clk;
    logic       rst_n;
    logic [6:0] in_char1, in_char2;
    logic       in_valid1, in_valid2;
    logic       in_ready1, in_ready2;
    logic       tx1, tx2;
    logic       busy1, busy2;
    logic       overflow1, overflow2;
    logic [2:0] fifo_count1, fifo_count2;

    int error_count = 0;
    int check_count = 0;

    bit cap_en  = 1'b0;
    int cap_sel = 0;
    bit log_tx[$];
    bit log_busy[$];
    bit exp_tx[$];
    bit exp_busy[$];

    char_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_char(in_char1), .in_valid(in_valid1),
        .in_ready(in_ready1), .tx(tx1), .busy(busy1), .overflow(overflow1),
        .fifo_count(fifo_count1)
    );

    char_uart_tx #(.CLKS_PER_BIT(1), .FIFO_DEPTH(4), .PARITY_EN(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_char(in_char2), .in_valid(in_valid2),
        .in_ready(in_ready2), .tx(tx2), .busy(busy2), .overflow(overflow2),
        .fifo_count(fifo_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cap_en) begin
            log_tx.push_back(cap_sel == 0 ? tx1 : tx2);
            log_busy.push_back(cap_sel == 0 ? busy1 : busy2);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int sel, input bit valid, input logic [6:0] ch);
        if (sel == 0) begin
            in_valid1 = valid;
            in_char1  = ch;
        end else begin
            in_valid2 = valid;
            in_char2  = ch;
        end
    endtask

    task automatic startCapture(input int sel);
        log_tx.delete();
        log_busy.delete();
        exp_tx.delete();
        exp_busy.delete();
        cap_sel = sel;
        cap_en  = 1'b1;
    endtask

    task automatic expIdle(input int n);
        repeat (n) begin
            exp_tx.push_back(1'b1);
            exp_busy.push_back(1'b0);
        end
    endtask

    // Frame model: start, data LSB first, optional even parity, stop.
    task automatic expFrame(input logic [6:0] ch, input int cpb, input bit par);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 7; i++) bits.push_back(ch[i]);
        if (par) bits.push_back(^ch);
        bits.push_back(1'b1);
        foreach (bits[b]) begin
            repeat (cpb) begin
                exp_tx.push_back(bits[b]);
                exp_busy.push_back(1'b1);
            end
        end
    endtask

    task automatic finishCapture(input string tag);
        int guard = 0;
        int tx_errs = 0;
        int busy_errs = 0;
        int n;
        while (log_tx.size() < exp_tx.size() && guard < exp_tx.size() + 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        cap_en = 1'b0;
        n = (log_tx.size() < exp_tx.size()) ? log_tx.size() : exp_tx.size();
        for (int i = 0; i < n; i++) begin
            if (log_tx[i] !== exp_tx[i]) tx_errs++;
            if (log_busy[i] !== exp_busy[i]) busy_errs++;
        end
        checkOutput({tag, "_len"}, log_tx.size(), exp_tx.size());
        checkOutput({tag, "_tx_errs"}, tx_errs, 0);
        checkOutput({tag, "_busy_errs"}, busy_errs, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 1'b0, 7'h00);
        applyStimulus(1, 1'b0, 7'h00);

        // Reset values and a quiet line afterwards
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_tx", tx1, 1);
        checkOutput("rst_busy", busy1, 0);
        checkOutput("rst_in_ready", in_ready1, 1);
        checkOutput("rst_overflow", overflow1, 0);
        checkOutput("rst_count", fifo_count1, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        startCapture(0);
        expIdle(50);
        finishCapture("t1_idle");

        // Single 'P' frame with parity, 4 clocks per bit
        @(posedge clk); #1; applyStimulus(0, 1'b1, 7'h50);
        @(posedge clk); #1; applyStimulus(0, 1'b0, 7'h00);
        startCapture(0);
        expIdle(1); expFrame(7'h50, 4, 1'b1); expIdle(9);
        finishCapture("t2_P");

        // 1 clock per bit, no parity: 0x7F then 0x15 back to back
        @(posedge clk); #1; applyStimulus(1, 1'b1, 7'h7F);
        @(posedge clk); #1; applyStimulus(1, 1'b1, 7'h15);
        startCapture(1);
        @(posedge clk); #1; applyStimulus(1, 1'b0, 7'h00);
        expIdle(1); expFrame(7'h7F, 1, 1'b0); expFrame(7'h15, 1, 1'b0); expIdle(5);
        finishCapture("t4_fast");

        // Burst of six characters into a four-deep FIFO
        @(posedge clk); #1; applyStimulus(0, 1'b1, "A");
        @(posedge clk); #1; startCapture(0); applyStimulus(0, 1'b1, "B");
        @(posedge clk); #1; applyStimulus(0, 1'b1, "C");
        @(posedge clk); #1; applyStimulus(0, 1'b1, "D");
        @(posedge clk); #1; applyStimulus(0, 1'b1, "E");
        @(posedge clk); #1;
        checkOutput("t3_ready_full", in_ready1, 0);
        checkOutput("t3_count_full", fifo_count1, 4);
        checkOutput("t3_ovf_before", overflow1, 0);
        applyStimulus(0, 1'b1, "F");
        @(posedge clk); #1;
        checkOutput("t3_ovf_after", overflow1, 1);
        checkOutput("t3_count_drop", fifo_count1, 4);
        checkOutput("t3_ready_drop", in_ready1, 0);
        applyStimulus(0, 1'b0, 7'h00);
        expIdle(1);
        expFrame("A", 4, 1'b1); expFrame("B", 4, 1'b1); expFrame("C", 4, 1'b1);
        expFrame("D", 4, 1'b1); expFrame("E", 4, 1'b1);
        expIdle(10);
        finishCapture("t3_burst");

        // Push lands on the same edge as the end of a stop bit
        @(posedge clk); #1; applyStimulus(0, 1'b1, "a");
        @(posedge clk); #1; startCapture(0); applyStimulus(0, 1'b1, "b");
        @(posedge clk); #1; applyStimulus(0, 1'b1, "c");
        @(posedge clk); #1; applyStimulus(0, 1'b0, 7'h00);
        repeat (38) @(posedge clk);
        #1;
        checkOutput("t6_count_before", fifo_count1, 2);
        applyStimulus(0, 1'b1, "d");
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 7'h00);
        checkOutput("t6_count_after", fifo_count1, 2);
        expIdle(1);
        expFrame("a", 4, 1'b1); expFrame("b", 4, 1'b1);
        expFrame("c", 4, 1'b1); expFrame("d", 4, 1'b1);
        expIdle(10);
        finishCapture("t6_pushpop");

        // Asynchronous reset during data bit 3 of 'C' with two characters queued
        @(posedge clk); #1; applyStimulus(0, 1'b1, "C");
        @(posedge clk); #1; applyStimulus(0, 1'b1, "D");
        @(posedge clk); #1; applyStimulus(0, 1'b1, "E");
        @(posedge clk); #1; applyStimulus(0, 1'b0, 7'h00);
        checkOutput("t5_count_queued", fifo_count1, 2);
        repeat (16) @(posedge clk);
        #2;
        checkOutput("t5_tx_bit3", tx1, 0);
        checkOutput("t5_busy_mid", busy1, 1);
        checkOutput("t5_ovf_sticky", overflow1, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_tx_async", tx1, 1);
        checkOutput("t5_count_async", fifo_count1, 0);
        checkOutput("t5_busy_async", busy1, 0);
        checkOutput("t5_ovf_async", overflow1, 0);
        checkOutput("t5_ready_async", in_ready1, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        startCapture(0);
        expIdle(30);
        finishCapture("t5_after");
        checkOutput("t5_count_after", fifo_count1, 0);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
